// File: rtl/pipe_hazard_ctrl_if.sv
// Issue-side bundle between decode and the hazard/forwarding controller.
//
// Handshake: decode holds issue_valid and the operand/destination fields
// stable for the cycle. The instruction is taken in that cycle when
// issue_ready=1 and issue_kill=0. When issue_kill=1 the issue is discarded
// as wrong-path even though issue_ready=1. When issue_ready=0 decode must
// present the same instruction again next cycle.
//
// master : decode side (drives issue_* and branch_taken)
// slave  : pipe_hazard_ctrl (drives ready/kill, forwarding selects, flush,
//          stall_count and the fsm_state debug bit)
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic [RA_W-1:0]  issue_rs1;
    logic [RA_W-1:0]  issue_rs2;
    logic             issue_uses_rs1;
    logic             issue_uses_rs2;
    logic [RA_W-1:0]  issue_rd;
    logic             issue_wen;
    logic             issue_is_load;
    logic             branch_taken;
    logic             issue_ready;
    logic             issue_kill;
    logic [SEL_W-1:0] fwd_sel_rs1;
    logic [SEL_W-1:0] fwd_sel_rs2;
    logic             flush;
    logic [15:0]      stall_count;
    logic             fsm_state;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_uses_rs1,
               issue_uses_rs2, issue_rd, issue_wen, issue_is_load,
               branch_taken,
        input  issue_ready, issue_kill, fwd_sel_rs1, fwd_sel_rs2,
               flush, stall_count, fsm_state
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_uses_rs1,
               issue_uses_rs2, issue_rd, issue_wen, issue_is_load,
               branch_taken,
        output issue_ready, issue_kill, fwd_sel_rs1, fwd_sel_rs2,
               flush, stall_count, fsm_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order integer pipeline.
// Tracks DEPTH in-flight register writes, selects the forwarding source per
// operand (youngest match wins), stalls on load-use, and kills FLUSH_SLOTS
// issue cycles after a taken branch.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : pipe_hazard_ctrl_if.slave (issue handshake, branch_taken,
//           fwd selects, flush pulse, stall_count, fsm_state debug bit)
module pipe_hazard_ctrl #(
    parameter int RA_W        = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS) : 1;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    // Index 0 holds stage 1 (youngest), index DEPTH-1 holds stage DEPTH.
    logic [DEPTH-1:0]           sb_valid;
    logic [DEPTH-1:0][RA_W-1:0] sb_rd;
    logic [DEPTH-1:0]           sb_load;

    logic [SEL_W:0]   look1, look2;
    logic             haz, kill, ready, insert;

    // Returns {hazard, sel}. Scanning from oldest to youngest lets the
    // youngest match overwrite older ones.
    function automatic logic [SEL_W:0] lookup(
        input logic                       used,
        input logic [RA_W-1:0]            src,
        input logic [DEPTH-1:0]           v,
        input logic [DEPTH-1:0][RA_W-1:0] rd,
        input logic [DEPTH-1:0]           ld
    );
        logic [SEL_W-1:0] sel;
        logic             h;
        sel = '0;
        h   = 1'b0;
        if (used && (src != '0)) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (v[k-1] && (rd[k-1] == src)) begin
                    sel = SEL_W'(k);
                    h   = ld[k-1] && (k <= LOAD_LAT);
                end
            end
        end
        return {h, sel};
    endfunction

    always_comb begin
        look1  = lookup(bus.issue_uses_rs1, bus.issue_rs1, sb_valid, sb_rd, sb_load);
        look2  = lookup(bus.issue_uses_rs2, bus.issue_rs2, sb_valid, sb_rd, sb_load);
        haz    = look1[SEL_W] | look2[SEL_W];
        kill   = bus.branch_taken | (state == FLUSH);
        // A wrong-path issue is consumed (and dropped), so stalls are moot.
        ready  = kill | ~haz;
        insert = bus.issue_valid & ready & ~kill & bus.issue_wen
                 & (bus.issue_rd != '0);
    end

    assign bus.issue_ready = ready;
    assign bus.issue_kill  = kill;
    assign bus.fwd_sel_rs1 = look1[SEL_W-1:0];
    assign bus.fwd_sel_rs2 = look2[SEL_W-1:0];
    assign bus.fsm_state   = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (bus.branch_taken) begin
            // The branch cycle itself is slot 1; the counter covers the rest.
            if (FLUSH_SLOTS > 1) begin
                state_nx = FLUSH;
                cnt_nx   = CNT_W'(FLUSH_SLOTS - 1);
            end else begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        end else if (state == FLUSH) begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt_nx == '0) begin
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_valid <= '0;
            sb_rd    <= '0;
            sb_load  <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_rd[k]    <= sb_rd[k-1];
                sb_load[k]  <= sb_load[k-1];
            end
            sb_valid[0] <= insert;
            sb_rd[0]    <= bus.issue_rd;
            sb_load[0]  <= bus.issue_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.flush       <= 1'b0;
            bus.stall_count <= '0;
        end else begin
            bus.flush <= bus.branch_taken;
            if (bus.issue_valid && !ready && (bus.stall_count != 16'hFFFF)) begin
                bus.stall_count <= bus.stall_count + 16'd1;
            end
        end
    end
endmodule
